// File: rtl/path_store_if.sv
// Path stream carrying the traced shortest path, dest first, source last.
// The master drives the beats and the slave applies backpressure with path_ready.
interface path_store_if #(
  parameter int INDEX_WIDTH = 4
);
  logic                   path_valid;
  logic                   path_ready;
  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_last;
  logic                   trace_error;

  modport master (
    output path_valid,
    output path_node,
    output path_last,
    output trace_error,
    input  path_ready
  );

  modport slave (
    input  path_valid,
    input  path_node,
    input  path_last,
    input  trace_error,
    output path_ready
  );
endinterface

// File: rtl/path_store.sv
// Visited/predecessor store for the Dijkstra core.
// It has a sequential clear, a registered read port and a path-trace streamer.
module path_store #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  input  logic [INDEX_WIDTH:0]   number_of_nodes,
  output logic                   ready,
  input  logic                   set_en,
  input  logic [INDEX_WIDTH-1:0] set_index,
  input  logic [INDEX_WIDTH-1:0] set_prev,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [INDEX_WIDTH-1:0] rd_prev,
  output logic                   rd_visited,
  output logic [INDEX_WIDTH:0]   unvisited_nodes,
  output logic                   all_visited,
  input  logic                   trace_start,
  input  logic [INDEX_WIDTH-1:0] trace_dest,
  input  logic [INDEX_WIDTH-1:0] trace_source,
  path_store_if.master           path
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_TRACE = 2'd2;

  localparam logic [INDEX_WIDTH:0]   MAX_COUNT = (INDEX_WIDTH+1)'(MAX_NODES);
  localparam logic [INDEX_WIDTH-1:0] LAST_PTR  = INDEX_WIDTH'(MAX_NODES - 1);

  logic [1:0]             state_q, state_d;
  logic [MAX_NODES-1:0]   visited_q, visited_d;
  logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];
  logic [INDEX_WIDTH:0]   n_q, n_d;
  logic [INDEX_WIDTH:0]   unvisited_q, unvisited_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [INDEX_WIDTH:0]   steps_q, steps_d;
  logic [INDEX_WIDTH-1:0] source_q, source_d;
  logic [INDEX_WIDTH-1:0] rd_prev_q, rd_prev_d;
  logic                   rd_visited_q, rd_visited_d;

  logic                 trace_last;
  logic                 set_ok;
  logic                 rd_in_range;
  logic [INDEX_WIDTH:0] n_clamped;

  // The step limit bounds every trace, so predecessor cycles cannot run forever.
  assign trace_last  = (cur_q == source_q) || !visited_q[cur_q] || (steps_q == n_q);
  assign set_ok      = set_en && ({1'b0, set_index} < n_q) && !visited_q[set_index];
  assign rd_in_range = ({1'b0, rd_index} < MAX_COUNT);
  assign n_clamped   = (number_of_nodes > MAX_COUNT) ? MAX_COUNT : number_of_nodes;

  always_comb begin
    state_d      = state_q;
    visited_d    = visited_q;
    prev_d       = prev_q;
    n_d          = n_q;
    unvisited_d  = unvisited_q;
    ptr_d        = ptr_q;
    cur_d        = cur_q;
    steps_d      = steps_q;
    source_d     = source_q;
    rd_prev_d    = '0;
    rd_visited_d = 1'b0;

    if (rd_in_range) begin
      rd_prev_d    = prev_q[rd_index];
      rd_visited_d = visited_q[rd_index];
    end

    case (state_q)
      ST_IDLE: begin
        if (init) begin
          n_d         = n_clamped;
          unvisited_d = n_clamped;
          ptr_d       = '0;
          state_d     = ST_CLEAR;
        end else begin
          // A same-cycle set lands in the array before the trace reads it.
          if (set_ok) begin
            visited_d[set_index] = 1'b1;
            prev_d[set_index]    = set_prev;
            if (unvisited_q != '0) begin
              unvisited_d = unvisited_q - 1'b1;
            end
          end
          if (trace_start && ({1'b0, trace_dest} < n_q)) begin
            state_d  = ST_TRACE;
            cur_d    = trace_dest;
            steps_d  = (INDEX_WIDTH+1)'(1);
            source_d = trace_source;
          end
        end
      end
      ST_CLEAR: begin
        visited_d[ptr_q] = 1'b0;
        prev_d[ptr_q]    = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_TRACE: begin
        if (path.path_ready) begin
          if (trace_last) begin
            state_d = ST_IDLE;
          end else begin
            cur_d   = prev_q[cur_q];
            steps_d = steps_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      visited_q    <= '0;
      prev_q       <= '{default: '0};
      n_q          <= '0;
      unvisited_q  <= '0;
      ptr_q        <= '0;
      cur_q        <= '0;
      steps_q      <= '0;
      source_q     <= '0;
      rd_prev_q    <= '0;
      rd_visited_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      visited_q    <= visited_d;
      prev_q       <= prev_d;
      n_q          <= n_d;
      unvisited_q  <= unvisited_d;
      ptr_q        <= ptr_d;
      cur_q        <= cur_d;
      steps_q      <= steps_d;
      source_q     <= source_d;
      rd_prev_q    <= rd_prev_d;
      rd_visited_q <= rd_visited_d;
    end
  end

  assign ready            = (state_q == ST_IDLE);
  assign all_visited      = (unvisited_q == '0) && ready;
  assign unvisited_nodes  = unvisited_q;
  assign rd_prev          = rd_prev_q;
  assign rd_visited       = rd_visited_q;

  // Beat flags derive from held state, so they stay stable while stalled.
  assign path.path_valid  = (state_q == ST_TRACE);
  assign path.path_node   = cur_q;
  assign path.path_last   = path.path_valid && trace_last;
  assign path.trace_error = path.path_valid && trace_last && (cur_q != source_q);

endmodule

// File: tb/tb_path_store.sv
// Directed bench for path_store: clear, set, read port, path trace and reset abort.
// Expected values are hand-computed for a 16-entry store with 5 active nodes.
module tb_path_store;

  logic       clock = 1'b0;
  logic       reset;
  logic       init;
  logic [4:0] number_of_nodes;
  logic       ready;
  logic       set_en;
  logic [3:0] set_index;
  logic [3:0] set_prev;
  logic [3:0] rd_index;
  logic [3:0] rd_prev;
  logic       rd_visited;
  logic [4:0] unvisited_nodes;
  logic       all_visited;
  logic       trace_start;
  logic [3:0] trace_dest;
  logic [3:0] trace_source;

  int checks = 0;
  int errors = 0;
  int low_cycles;
  int exp_nodes [5] = '{1, 2, 1, 2, 1};

  path_store_if #(.INDEX_WIDTH(4)) pif ();

  path_store #(.MAX_NODES(16), .INDEX_WIDTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .init            (init),
    .number_of_nodes (number_of_nodes),
    .ready           (ready),
    .set_en          (set_en),
    .set_index       (set_index),
    .set_prev        (set_prev),
    .rd_index        (rd_index),
    .rd_prev         (rd_prev),
    .rd_visited      (rd_visited),
    .unvisited_nodes (unvisited_nodes),
    .all_visited     (all_visited),
    .trace_start     (trace_start),
    .trace_dest      (trace_dest),
    .trace_source    (trace_source),
    .path            (pif.master)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Counts cycles with ready low; a bounded loop keeps a stuck clear from hanging.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 40) begin
      cycles++;
      applyStimulus(1);
    end
  endtask

  task automatic do_set(input logic [3:0] idx, input logic [3:0] prv);
    set_en    = 1'b1;
    set_index = idx;
    set_prev  = prv;
    applyStimulus(1);
    set_en    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; number_of_nodes = '0; set_en = 1'b0;
    set_index = '0; set_prev = '0; rd_index = '0; trace_start = 1'b0;
    trace_dest = '0; trace_source = '0; pif.path_ready = 1'b0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_unvisited", 32'(unvisited_nodes), 32'd0);
    checkOutput("rst_all_visited", 32'(all_visited), 32'd1);
    checkOutput("rst_path_valid", 32'(pif.path_valid), 32'd0);
    checkOutput("rst_rd_prev", 32'(rd_prev), 32'd0);

    $display("[TB] init n=5 and clear sequence");
    init = 1'b1; number_of_nodes = 5'd5;
    applyStimulus(1);
    init = 1'b0;
    wait_ready(low_cycles);
    checkOutput("clear_cycles", 32'(low_cycles), 32'd16);
    checkOutput("init_unvisited", 32'(unvisited_nodes), 32'd5);
    checkOutput("init_all_visited", 32'(all_visited), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd_index = 4'(i);
      applyStimulus(1);
      checkOutput("init_rd_visited", 32'(rd_visited), 32'd0);
    end

    $display("[TB] first write wins");
    do_set(4'd2, 4'd0);
    do_set(4'd2, 4'd3);
    checkOutput("set_unvisited", 32'(unvisited_nodes), 32'd4);
    rd_index = 4'd2;
    applyStimulus(1);
    checkOutput("set_rd_prev", 32'(rd_prev), 32'd0);
    checkOutput("set_rd_visited", 32'(rd_visited), 32'd1);

    $display("[TB] out-of-range and busy sets ignored");
    do_set(4'd7, 4'd1);
    checkOutput("oor7_unvisited", 32'(unvisited_nodes), 32'd4);
    do_set(4'd5, 4'd1);
    checkOutput("oor5_unvisited", 32'(unvisited_nodes), 32'd4);
    init = 1'b1; number_of_nodes = 5'd5;
    applyStimulus(1);
    init = 1'b0;
    set_en = 1'b1; set_index = 4'd4; set_prev = 4'd1;
    wait_ready(low_cycles);
    set_en = 1'b0;
    checkOutput("clear2_cycles", 32'(low_cycles), 32'd16);
    checkOutput("clear_set_unvisited", 32'(unvisited_nodes), 32'd5);
    rd_index = 4'd4;
    applyStimulus(1);
    checkOutput("clear_set_rd4", 32'(rd_visited), 32'd0);
    rd_index = 4'd2;
    applyStimulus(1);
    checkOutput("clear_rd2", 32'(rd_visited), 32'd0);

    $display("[TB] trace 3->1->0 with backpressure");
    do_set(4'd0, 4'd0);
    do_set(4'd1, 4'd0);
    do_set(4'd3, 4'd1);
    checkOutput("t4_unvisited", 32'(unvisited_nodes), 32'd2);
    pif.path_ready = 1'b0;
    trace_start = 1'b1; trace_dest = 4'd3; trace_source = 4'd0;
    applyStimulus(1);
    trace_start = 1'b0;
    checkOutput("t4_valid0", 32'(pif.path_valid), 32'd1);
    checkOutput("t4_ready_low", 32'(ready), 32'd0);
    checkOutput("t4_node0", 32'(pif.path_node), 32'd3);
    checkOutput("t4_last0", 32'(pif.path_last), 32'd0);
    pif.path_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t4_node1", 32'(pif.path_node), 32'd1);
    checkOutput("t4_last1", 32'(pif.path_last), 32'd0);
    pif.path_ready = 1'b0;
    applyStimulus(1);
    checkOutput("t4_stall_valid", 32'(pif.path_valid), 32'd1);
    checkOutput("t4_stall_node", 32'(pif.path_node), 32'd1);
    pif.path_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t4_node2", 32'(pif.path_node), 32'd0);
    checkOutput("t4_last2", 32'(pif.path_last), 32'd1);
    checkOutput("t4_error2", 32'(pif.trace_error), 32'd0);
    pif.path_ready = 1'b0;
    applyStimulus(1);
    checkOutput("t4_stall_last_node", 32'(pif.path_node), 32'd0);
    checkOutput("t4_stall_last", 32'(pif.path_last), 32'd1);
    pif.path_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t4_done_valid", 32'(pif.path_valid), 32'd0);
    checkOutput("t4_done_ready", 32'(ready), 32'd1);

    $display("[TB] trace from unvisited node");
    trace_start = 1'b1; trace_dest = 4'd4; trace_source = 4'd0;
    applyStimulus(1);
    trace_start = 1'b0;
    checkOutput("t5_node", 32'(pif.path_node), 32'd4);
    checkOutput("t5_last", 32'(pif.path_last), 32'd1);
    checkOutput("t5_error", 32'(pif.trace_error), 32'd1);
    applyStimulus(1);
    checkOutput("t5_done_valid", 32'(pif.path_valid), 32'd0);
    trace_start = 1'b1; trace_dest = 4'd5;
    applyStimulus(1);
    trace_start = 1'b0;
    checkOutput("oor_dest_valid", 32'(pif.path_valid), 32'd0);
    checkOutput("oor_dest_ready", 32'(ready), 32'd1);

    $display("[TB] predecessor loop bounded by n");
    init = 1'b1; number_of_nodes = 5'd5;
    applyStimulus(1);
    init = 1'b0;
    wait_ready(low_cycles);
    checkOutput("t6_clear_cycles", 32'(low_cycles), 32'd16);
    do_set(4'd1, 4'd2);
    do_set(4'd2, 4'd1);
    trace_start = 1'b1; trace_dest = 4'd1; trace_source = 4'd0;
    applyStimulus(1);
    trace_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t6_valid", 32'(pif.path_valid), 32'd1);
      checkOutput("t6_node", 32'(pif.path_node), 32'(exp_nodes[i]));
      checkOutput("t6_last", 32'(pif.path_last), (i == 4) ? 32'd1 : 32'd0);
      checkOutput("t6_error", 32'(pif.trace_error), (i == 4) ? 32'd1 : 32'd0);
      applyStimulus(1);
    end
    checkOutput("t6_done_valid", 32'(pif.path_valid), 32'd0);

    $display("[TB] reset aborts a running trace");
    trace_start = 1'b1;
    applyStimulus(1);
    trace_start = 1'b0;
    applyStimulus(1);
    checkOutput("abort_pre_node", 32'(pif.path_node), 32'd2);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("abort_valid", 32'(pif.path_valid), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_unvisited", 32'(unvisited_nodes), 32'd0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("abort_still_idle", 32'(pif.path_valid), 32'd0);

    $display("[TB] node count clamps to capacity");
    init = 1'b1; number_of_nodes = 5'd20;
    applyStimulus(1);
    init = 1'b0;
    wait_ready(low_cycles);
    checkOutput("clamp_unvisited", 32'(unvisited_nodes), 32'd16);
    do_set(4'd15, 4'd9);
    checkOutput("clamp_set15", 32'(unvisited_nodes), 32'd15);
    rd_index = 4'd15;
    applyStimulus(1);
    checkOutput("clamp_rd_prev", 32'(rd_prev), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
